cla_wide_add_seq: RTL and testbench

Multi-cycle sequencer that performs WORDS×32-bit add/subtract by time-sharing one CLAdder_32bit instance (ports x, y, cin, sum, cout), one 32-bit word per clock, LSW first.
- The carry out of each word is registered and fed back as the next word's carry in.
- Start/busy/done handshake toward the requesting logic.
- Gives the design wide arithmetic without replicating the 32-bit CLA.

---
 rtl/cla_wide_add_seq_if.sv | 42 ++++
 rtl/cla_wide_add_seq.sv | 151 +++++++++++++++
 tb/tb_cla_wide_add_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cla_wide_add_seq_if.sv
// ---------------------------------------------------------------------------
// cla_wide_add_seq_if
//   Request/result bundle for the multi-word CLA add/subtract sequencer.
//   master: requesting logic (drives start/a/b/cin/sub, observes results)
//   slave : the sequencer itself
//   Signals:
//     start        request, sampled only while busy=0
//     a, b         W-bit operands (W = 32*WORDS)
//     cin          carry in for add (ignored when sub=1)
//     sub          1 = a - b
//     busy         operation in progress
//     done         one-cycle pulse, result registers valid
//     sum          W-bit result
//     cout         final carry out (for sub: 1 = no borrow)
//     ovf          two's-complement signed overflow of the W-bit result
// ---------------------------------------------------------------------------
interface cla_wide_add_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 32 * WORDS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/cla_wide_add_seq.sv
// ---------------------------------------------------------------------------
// cla_wide_add_seq
//   Wide (32*WORDS-bit) add/subtract built by time-sharing a single 32-bit
//   carry-lookahead adder, one word per clock, least significant word first.
//   The carry out of each word is registered and becomes the next word's
//   carry in. A start/busy/done handshake frames each operation; the result
//   is valid from the done cycle until the next accepted start.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   cla_wide_add_seq_if.slave (start/a/b/cin/sub in,
//           busy/done/sum/cout/ovf out)
// ---------------------------------------------------------------------------

// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries
// chained through group generate/propagate terms.
module CLAdder_32bit (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g;
  logic [31:0] p;

  assign g = x & y;
  assign p = x ^ y;

  always_comb begin
    logic [32:0] c;
    logic        gg;
    logic        gp;
    int          b;
    // NOTE: every combinational output gets a default before any
    // conditional/looped update so no latch can be inferred.
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < 8; k++) begin
      b = 4 * k;
      gg = g[b+3] | (p[b+3] & g[b+2]) | (p[b+3] & p[b+2] & g[b+1])
         | (p[b+3] & p[b+2] & p[b+1] & g[b]);
      gp = &p[b +: 4];
      c[b+1] = g[b] | (p[b] & c[b]);
      c[b+2] = g[b+1] | (p[b+1] & g[b]) | (p[b+1] & p[b] & c[b]);
      c[b+3] = g[b+2] | (p[b+2] & g[b+1]) | (p[b+2] & p[b+1] & g[b])
             | (p[b+2] & p[b+1] & p[b] & c[b]);
      c[b+4] = gg | (gp & c[b]);
    end
    sum  = p ^ c[31:0];
    cout = c[32];
  end
endmodule

module cla_wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  cla_wide_add_seq_if.slave   bus
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state;
  logic [WORDS-1:0][31:0] a_r;
  logic [WORDS-1:0][31:0] b_r;     // already inverted for subtract
  logic [WORDS-1:0][31:0] sum_r;
  logic [IW-1:0]          idx;
  logic                   carry_r;
  logic                   cout_r;
  logic                   ovf_r;
  logic                   busy_r;
  logic                   done_r;

  logic [31:0]            cla_sum;
  logic                   cla_cout;
  logic                   last_word;
  logic                   accept;

  assign accept    = (state == IDLE) && bus.start;
  assign last_word = (idx == IW'(WORDS - 1));

  CLAdder_32bit u_cla (
    .x    (a_r[idx]),
    .y    (b_r[idx]),
    .cin  (carry_r),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // NOTE: operand registers carry no reset; they are only read while RUN,
  // and RUN is always entered through a load, so reset would buy nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= bus.a;
      b_r <= bus.sub ? ~bus.b : bus.b;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sum_r   <= '0;
      idx     <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Subtract is A + ~B + 1: the +1 rides in on the first carry.
            carry_r <= bus.sub | bus.cin;
            idx     <= '0;
            busy_r  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_r[idx] <= cla_sum;
          carry_r    <= cla_cout;
          idx        <= idx + 1'b1;
          if (last_word) begin
            cout_r <= cla_cout;
            // Signed overflow: operands agree in sign, result does not.
            ovf_r  <= (a_r[idx][31] == b_r[idx][31]) &&
                      (cla_sum[31] != a_r[idx][31]);
            done_r <= 1'b1;
            busy_r <= 1'b0;
            idx    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_cla_wide_add_seq.sv
// ---------------------------------------------------------------------------
// tb_cla_wide_add_seq
//   Directed bench for cla_wide_add_seq with WORDS=4 (128-bit operands).
//   Inputs change just after the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_cla_wide_add_seq;
  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cla_wide_add_seq_if #(.WORDS(WORDS)) bus ();

  cla_wide_add_seq #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called right after a falling edge; start is seen at the next rising
  // edge (E0). Returns just after the falling edge following E0.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.sub   = sub;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done; checks edge count and busy sample count.
  task automatic wait_done(input string tag, input int exp_n);
    int n     = 0;
    int nbusy = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, W'(n), W'(exp_n));
    check({tag, ".busy_cycles"}, W'(nbusy), W'(exp_n));
    check({tag, ".done"}, W'(bus.done), W'(1));
    check({tag, ".busy_at_done"}, W'(bus.busy), W'(0));
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] s,
                              input logic c, input logic v);
    check({tag, ".sum"}, bus.sum, s);
    check({tag, ".cout"}, W'(bus.cout), W'(c));
    check({tag, ".ovf"}, W'(bus.ovf), W'(v));
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.busy", W'(bus.busy), W'(0));
    check("reset.done", W'(bus.done), W'(0));
    check_result("reset", '0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 1 + 2
    start_op(W'(1), W'(2), 1'b0, 1'b0);
    check("add1.busy_after_start", W'(bus.busy), W'(1));
    wait_done("add1", WORDS);
    check_result("add1", W'(3), 1'b0, 1'b0);
    @(negedge clk);
    check("add1.done_pulse_ends", W'(bus.done), W'(0));
    check("add1.sum_holds", bus.sum, W'(3));

    // 1 + 2 + cin
    start_op(W'(1), W'(2), 1'b1, 1'b0);
    wait_done("add1c", WORDS);
    check_result("add1c", W'(4), 1'b0, 1'b0);
    @(negedge clk);

    // Carry ripples through three full words
    start_op({32'h0, {96{1'b1}}}, W'(1), 1'b0, 1'b0);
    wait_done("carry3", WORDS);
    check_result("carry3", {32'h1, 96'h0}, 1'b0, 1'b0);
    @(negedge clk);

    // all-ones + 0 + cin wraps to zero with carry out
    start_op(ONES, '0, 1'b1, 1'b0);
    wait_done("wrap", WORDS);
    check_result("wrap", '0, 1'b1, 1'b0);
    @(negedge clk);

    // 5 - 16 borrows (cin ignored on subtract)
    start_op(W'(5), W'(16), 1'b0, 1'b1);
    wait_done("sub_neg", WORDS);
    check_result("sub_neg", {{(W-8){1'b1}}, 8'hF5}, 1'b0, 1'b0);
    @(negedge clk);

    // 16 - 5
    start_op(W'(16), W'(5), 1'b1, 1'b1);
    wait_done("sub_pos", WORDS);
    check_result("sub_pos", W'(11), 1'b1, 1'b0);
    @(negedge clk);

    // Max positive + 1 overflows
    start_op(SMAX, W'(1), 1'b0, 1'b0);
    wait_done("ovf_add", WORDS);
    check_result("ovf_add", SMIN, 1'b0, 1'b1);
    @(negedge clk);

    // Min negative - 1 overflows, no borrow
    start_op(SMIN, W'(1), 1'b0, 1'b1);
    wait_done("ovf_sub", WORDS);
    check_result("ovf_sub", SMAX, 1'b1, 1'b1);
    @(negedge clk);

    // start while busy is ignored
    start_op(W'(100), W'(200), 1'b0, 1'b0);
    @(negedge clk);
    bus.a     = W'(7);
    bus.b     = W'(7);
    bus.sub   = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore", WORDS - 2);
    check_result("ignore", W'(300), 1'b0, 1'b0);

    // start during the done cycle is accepted back-to-back
    start_op(W'(12), W'(18), 1'b0, 1'b0);
    check("b2b.busy_after_start", W'(bus.busy), W'(1));
    wait_done("b2b", WORDS);
    check_result("b2b", W'(30), 1'b0, 1'b0);
    @(negedge clk);

    // Reset in the middle of an operation
    start_op(W'(5), W'(16), 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.busy", W'(bus.busy), W'(0));
    check("rstmid.done", W'(bus.done), W'(0));
    check_result("rstmid", '0, 1'b0, 1'b0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (bus.done) seen++;
        @(negedge clk);
      end
      check("rstmid.no_done_pulse", W'(seen), W'(0));
    end

    start_op(W'(2), W'(3), 1'b1, 1'b0);
    wait_done("after_rst", WORDS);
    check_result("after_rst", W'(6), 1'b0, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
